tick_period_monitor: RTL
========================

Name: tick_period_monitor

Overview:
- Receive-side checker for the slow divided clock that the team's clock divider generates.
- Measures each half-period of a slow toggling input (sig_in) in fast clk cycles.
- Compares each measurement against an expected value and asserts `locked` after consecutive good measurements.
- Flags `timeout` when the input stops toggling.
- Sits beside divider outputs and feeds status LEDs and the display path.

Parameters:
- CW, 32, width of the interval counter and of period_out.
- EXP_HALF, 250_000, expected half-period in clk cycles (one toggle interval).
- TOL, 4, allowed absolute deviation from EXP_HALF, in cycles.
- LOCK_CNT, 3, number of consecutive good measurements required to assert locked.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  monitor enable; 0 forces IDLE.
- sig_in  input  1  slow toggling signal being measured; asynchronous to clk.
- period_out  output  CW  last measured half-period, in clk cycles.
- period_valid  output  1  one-cycle pulse when period_out updates.
- locked  output  1  input frequency is within tolerance.
- timeout  output  1  sticky flag: no edge seen within the timeout limit.

Behaviour:
- Reset: rst sampled high on a rising clk clears every register. Outputs period_out=0, period_valid=0, locked=0, timeout=0. State=IDLE, good_cnt=0, cnt=0.
- Input path: sig_in passes through a 2-flop synchronizer, then a history flop.
- Edge detection: edge = sync ^ hist, so both rising and falling edges count. edge is asserted 3 clk edges after sig_in changes.
- Interval counter cnt:
  - Cleared to 0 in the cycle edge=1.
  - Otherwise increments, saturating at 2^CW-1.
  - Measured interval D = cnt+1 at the edge, so a signal toggling every N clk cycles yields D=N.
- Good measurement: |D-EXP_HALF| <= TOL. The subtraction is computed in CW+1 bits, so no wrap-around.
- Timeout limit: TMO = 2*EXP_HALF+TOL.
- States:
  - IDLE: outputs held. locked=0, good_cnt=0. Moves to ACQUIRE when en=1.
  - ACQUIRE: waits for the first edge. That edge only starts cnt; it produces no period_valid. Moves to MEASURE.
  - MEASURE: on each edge, period_out<=D and period_valid=1 on the next cycle.
    - Good measurement: good_cnt++. If good_cnt reaches LOCK_CNT, go to LOCKED and set locked=1 in the same cycle as that period_valid.
    - Bad measurement: good_cnt=0.
  - LOCKED: on each edge, period_valid and period_out update.
    - Bad measurement: locked=0 in the same cycle as period_valid, good_cnt=0, go to MEASURE.
  - Timeout (MEASURE or LOCKED): when cnt reaches TMO with no edge, the next cycle has timeout=1, locked=0, good_cnt=0, state ACQUIRE.
  - timeout clears on the next detected edge.
- Latency: sig_in change to period_valid is 4 clk edges.
- Simultaneous events:
  - en=0 has priority over edge and timeout. The next cycle goes to IDLE and period_valid is suppressed.
  - An edge in the same cycle cnt hits TMO counts as an edge; no timeout is raised.
  - rst has priority over everything.
- Reset mid-operation: all state is lost. The monitor restarts in IDLE, with the first edge after reset treated as the acquisition edge.
- period_out holds its value between pulses. It is not cleared by en=0.

Optional Feature:
- Macro: TICK_MON_MINMAX_EN.
- Defined: adds outputs period_min and period_max (CW bits each, reset 0).
  - On the first period_valid after leaving IDLE, both load D.
  - After that, each is updated on every period_valid with the min/max.
  - Both are reinitialised on re-entry from IDLE.
- Undefined: these ports and their registers do not exist, and behaviour is otherwise identical.

Test Plan:
Bench parameters: CW=16, EXP_HALF=10, TOL=1, LOCK_CNT=3.
1. Reset: rst=1 for 2 cycles with sig_in toggling -> period_out=0, period_valid=0, locked=0, timeout=0.
2. en=1, sig_in toggles every 10 clk:
   - First edge gives no pulse.
   - The following edges pulse period_valid with period_out=10.
   - locked=1 coincides with the 3rd pulse.
3. Locked, then one interval of 13:
   - period_valid with period_out=13, locked=0 in that cycle.
   - Relock only on the 3rd subsequent 10-cycle interval.
4. Locked, then sig_in held static:
   - timeout=1 and locked=0 once cnt reaches 21.
   - The next edge clears timeout with no period_valid.
   - The following interval of 10 gives period_valid.
5. en driven 0 in the same cycle as an edge -> no period_valid, locked=0 next cycle. With en=1 again, the first edge is treated as acquisition.
6. With TICK_MON_MINMAX_EN, intervals 9, 11, 10 -> period_min=9, period_max=11. Without the macro, the same intervals give identical locked/period_out behaviour.

Source files
------------

// File: rtl/tick_period_monitor.sv
// Half-period monitor for a slow divided clock: measures toggle intervals, checks lock, flags timeout.
// Optional period_min/period_max outputs are built when TICK_MON_MINMAX_EN is defined.
module tick_period_monitor #(
    parameter int CW       = 32,
    parameter int EXP_HALF = 250_000,
    parameter int TOL      = 4,
    parameter int LOCK_CNT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          sig_in,
    output logic [CW-1:0] period_out,
    output logic          period_valid,
    output logic          locked,
    output logic          timeout
`ifdef TICK_MON_MINMAX_EN
    ,
    output logic [CW-1:0] period_min,
    output logic [CW-1:0] period_max
`endif
);

    localparam int            GW      = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW:0]   EXP_W   = (CW+1)'(EXP_HALF);
    localparam logic [CW:0]   TOL_W   = (CW+1)'(TOL);
    localparam logic [CW-1:0] TMO     = CW'(2 * EXP_HALF + TOL);
    localparam logic [GW-1:0] LAST_GOOD = GW'(LOCK_CNT - 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOCKED} state_t;

    state_t        state;
    logic          sync1, sync2, hist, edge_det;
    logic [CW-1:0] cnt;
    logic [GW-1:0] good_cnt;
    logic [CW-1:0] d;
    logic [CW:0]   dev;
    logic          good, tmo_hit, take;

    // Registered edge flag keeps sig_in-to-edge at three clk edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            hist     <= 1'b0;
            edge_det <= 1'b0;
        end else begin
            sync1    <= sig_in;
            sync2    <= sync1;
            hist     <= sync2;
            edge_det <= sync2 ^ hist;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (edge_det)
            cnt <= '0;
        else if (cnt != CNT_MAX)
            cnt <= cnt + CW'(1);
    end

    // Deviation is taken in CW+1 bits so a saturated count cannot wrap into tolerance.
    always_comb begin
        d       = (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);
        dev     = ({1'b0, d} >= EXP_W) ? ({1'b0, d} - EXP_W) : (EXP_W - {1'b0, d});
        good    = (dev <= TOL_W);
        tmo_hit = !edge_det && (cnt == TMO);
        take    = en && edge_det && (state == MEASURE || state == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            good_cnt     <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                IDLE: begin
                    locked   <= 1'b0;
                    good_cnt <= '0;
                    if (en)
                        state <= ACQUIRE;
                end
                ACQUIRE: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (edge_det) begin
                        timeout <= 1'b0;
                        state   <= MEASURE;
                    end
                end
                MEASURE, LOCKED: begin
                    if (!en) begin
                        state    <= IDLE;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end else if (edge_det) begin
                        period_out   <= d;
                        period_valid <= 1'b1;
                        if (!good) begin
                            good_cnt <= '0;
                            locked   <= 1'b0;
                            state    <= MEASURE;
                        end else if (state == MEASURE) begin
                            good_cnt <= good_cnt + GW'(1);
                            if (good_cnt == LAST_GOOD) begin
                                locked <= 1'b1;
                                state  <= LOCKED;
                            end
                        end
                    end else if (tmo_hit) begin
                        timeout  <= 1'b1;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                        state    <= ACQUIRE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TICK_MON_MINMAX_EN
    logic mm_fresh;

    // mm_fresh marks that the next measurement after IDLE seeds both extremes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mm_fresh   <= 1'b1;
            period_min <= '0;
            period_max <= '0;
        end else if (state == IDLE) begin
            mm_fresh <= 1'b1;
        end else if (take) begin
            mm_fresh <= 1'b0;
            if (mm_fresh || d < period_min)
                period_min <= d;
            if (mm_fresh || d > period_max)
                period_max <= d;
        end
    end
`endif

endmodule
